// File: rtl/uart_echo_fifo.sv
// Echo-path buffer between UART RX and TX: bytes captured on RX done are queued in a
// circular FIFO and handed to the transmitter one at a time with a level enable.
module uart_echo_fifo #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int GAP_CYC = 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [DATA_W-1:0] RX_Data,
    input  logic              RX_Done_Sig,
    input  logic              TX_Done_Sig,
    output logic              TX_En_Sig,
    output logic [DATA_W-1:0] TX_Data,
    output logic [ADDR_W:0]   Fifo_Count,
    output logic              Fifo_Full,
    output logic              Fifo_Empty,
    output logic              Overflow_Flag
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam int              GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd_data;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     w_count_next;
    logic                r_full;
    logic                r_empty;
    logic                r_overflow;
    logic                r_tx_en;
    logic [DATA_W-1:0]   r_tx_data;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                w_pop;
    logic                w_wr_en;

    // A full FIFO can still take a byte in the same cycle a slot is freed by a pop.
    assign w_pop   = (r_state == S_IDLE) && !r_empty;
    assign w_wr_en = RX_Done_Sig && (!r_full || w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_wr_en && !w_pop)
            w_count_next = r_count + 1'b1;
        else if (!w_wr_en && w_pop)
            w_count_next = r_count - 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (!r_empty) w_state_next = S_LOAD;
            S_LOAD: w_state_next = S_SEND;
            S_SEND: if (TX_Done_Sig) w_state_next = S_GAP;
            S_GAP:  if (r_gap_cnt == GAP_W'(GAP_CYC - 1)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // The popped byte is captured at the pop edge, before a simultaneous write can reuse its slot.
    always_ff @(posedge CLK) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= RX_Data;
        if (w_pop)
            r_rd_data <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_data  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == DEPTH_C);
            r_empty <= (w_count_next == '0);
            if (RX_Done_Sig && !w_wr_en)
                r_overflow <= 1'b1;
            r_tx_en <= (w_state_next == S_SEND);
            if (r_state == S_LOAD)
                r_tx_data <= r_rd_data;
            if (r_state == S_GAP)
                r_gap_cnt <= r_gap_cnt + 1'b1;
            else
                r_gap_cnt <= '0;
        end
    end

    assign TX_En_Sig     = r_tx_en;
    assign TX_Data       = r_tx_data;
    assign Fifo_Count    = r_count;
    assign Fifo_Full     = r_full;
    assign Fifo_Empty    = r_empty;
    assign Overflow_Flag = r_overflow;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench for uart_echo_fifo: stimulus queues expected bytes in arrival order,
// a negedge monitor pops and compares each byte as the transmitter enable rises.
`timescale 1ns/1ps
module tb_uart_echo_fifo;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int GAP_CYC = 2;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              CLK = 1'b0;
    logic              RSTn = 1'b0;
    logic [DATA_W-1:0] RX_Data = '0;
    logic              RX_Done_Sig = 1'b0;
    logic              TX_Done_Sig = 1'b0;
    logic              TX_En_Sig;
    logic [DATA_W-1:0] TX_Data;
    logic [ADDR_W:0]   Fifo_Count;
    logic              Fifo_Full;
    logic              Fifo_Empty;
    logic              Overflow_Flag;

    uart_echo_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .GAP_CYC(GAP_CYC)) dut (
        .CLK(CLK), .RSTn(RSTn), .RX_Data(RX_Data), .RX_Done_Sig(RX_Done_Sig),
        .TX_Done_Sig(TX_Done_Sig), .TX_En_Sig(TX_En_Sig), .TX_Data(TX_Data),
        .Fifo_Count(Fifo_Count), .Fifo_Full(Fifo_Full), .Fifo_Empty(Fifo_Empty),
        .Overflow_Flag(Overflow_Flag)
    );

    always #5 CLK = ~CLK;

    int                n_vec = 0;
    int                n_err = 0;
    logic [DATA_W-1:0] exp_q [$];
    bit                auto_tx = 0;
    bit                spurious = 0;
    int                hold_cnt = 0;
    int                hold_tgt = 2;
    logic              mon_prev_en = 1'b0;
    logic [DATA_W-1:0] mon_hold = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    // One clock; clears the RX pulse and drives TX_Done either manually (left low) or by a random responder.
    task automatic step();
        @(posedge CLK);
        #1;
        RX_Done_Sig = 1'b0;
        TX_Done_Sig = 1'b0;
        if (auto_tx) begin
            if (TX_En_Sig) begin
                if (hold_cnt >= hold_tgt) begin
                    TX_Done_Sig = 1'b1;
                    hold_cnt    = 0;
                    hold_tgt    = $urandom_range(1, 6);
                end else begin
                    hold_cnt++;
                end
            end else begin
                hold_cnt = 0;
                if (spurious && $urandom_range(0, 7) == 0)
                    TX_Done_Sig = 1'b1;
            end
        end
    endtask

    task automatic reset_dut();
        RSTn = 1'b0;
        auto_tx = 0;
        spurious = 0;
        RX_Done_Sig = 1'b0;
        TX_Done_Sig = 1'b0;
        exp_q.delete();
        repeat (3) step();
        RSTn = 1'b1;
        step();
    endtask

    task automatic write_byte(input logic [DATA_W-1:0] b, input bit expect_accept);
        RX_Data = b;
        RX_Done_Sig = 1'b1;
        if (expect_accept)
            exp_q.push_back(b);
        step();
    endtask

    task automatic wait_en(input int limit);
        for (int i = 0; i < limit && !TX_En_Sig; i++)
            step();
        check("wait_tx_en", TX_En_Sig, 1);
    endtask

    task automatic wait_drain(input string name, input int limit);
        auto_tx = 1;
        for (int i = 0; i < limit && !(exp_q.size() == 0 && Fifo_Empty && !TX_En_Sig); i++)
            step();
        repeat (GAP_CYC + 4) step();
        check({name, "_drained_q"}, exp_q.size(), 0);
        check({name, "_drained_cnt"}, Fifo_Count, 0);
    endtask

    always @(negedge CLK) begin
        if (!RSTn) begin
            mon_prev_en = 1'b0;
        end else begin
            if (TX_En_Sig && !mon_prev_en) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_unexpected: got byte %0h expected none at %0t", TX_Data, $time);
                end else begin
                    check("tx_data", TX_Data, exp_q.pop_front());
                end
                mon_hold = TX_Data;
            end else if (TX_En_Sig && TX_Data !== mon_hold) begin
                check("tx_data_stable", TX_Data, mon_hold);
            end
            mon_prev_en = TX_En_Sig;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        int low;
        // Reset and idle
        reset_dut();
        repeat (20) step();
        check("rst_tx_en", TX_En_Sig, 0);
        check("rst_tx_data", TX_Data, 0);
        check("rst_empty", Fifo_Empty, 1);
        check("rst_full", Fifo_Full, 0);
        check("rst_count", Fifo_Count, 0);
        check("rst_ovf", Overflow_Flag, 0);

        // Single byte latency: written in cycle N, enable seen in N+3, done in N+20
        write_byte(8'h5A, 1);
        check("single_n1_en", TX_En_Sig, 0);
        check("single_n1_cnt", Fifo_Count, 1);
        step();
        check("single_n2_en", TX_En_Sig, 0);
        check("single_n2_cnt", Fifo_Count, 0);
        step();
        check("single_n3_en", TX_En_Sig, 1);
        check("single_n3_data", TX_Data, 8'h5A);
        repeat (17) step();
        TX_Done_Sig = 1'b1;
        step();
        check("single_n21_en", TX_En_Sig, 0);
        check("single_n21_cnt", Fifo_Count, 0);

        // Burst of five with stalled transmitter, then measured gaps
        reset_dut();
        for (int i = 1; i <= 5; i++)
            write_byte(8'(i), 1);
        check("burst_peak_cnt", Fifo_Count, 4);
        for (int b = 0; b < 5; b++) begin
            wait_en(50);
            repeat ($urandom_range(1, 5)) step();
            TX_Done_Sig = 1'b1;
            step();
            check("burst_en_drop", TX_En_Sig, 0);
            if (b < 4) begin
                low = 1;
                while (!TX_En_Sig && low < 50) begin
                    step();
                    if (!TX_En_Sig)
                        low++;
                end
                check("burst_gap_len", low, GAP_CYC + 2);
            end
        end
        wait_drain("burst", 200);

        // Overflow: 18 writes with no TX_Done, 18th dropped
        reset_dut();
        for (int i = 1; i <= 16; i++)
            write_byte(8'h10 + 8'(i), 1);
        check("ovf_cnt16", Fifo_Count, DEPTH - 1);
        check("ovf_full16", Fifo_Full, 0);
        write_byte(8'h21, 1);
        check("ovf_full17", Fifo_Full, 1);
        check("ovf_cnt17", Fifo_Count, DEPTH);
        check("ovf_flag17", Overflow_Flag, 0);
        write_byte(8'h22, 0);
        check("ovf_flag18", Overflow_Flag, 1);
        check("ovf_cnt18", Fifo_Count, DEPTH);
        wait_drain("ovf", 1000);
        check("ovf_flag_sticky", Overflow_Flag, 1);

        // Full FIFO: write lands in the very cycle IDLE pops
        reset_dut();
        for (int i = 1; i <= 17; i++)
            write_byte(8'h40 + 8'(i), 1);
        check("fp_full", Fifo_Full, 1);
        repeat (3) step();
        TX_Done_Sig = 1'b1;
        step();
        check("fp_en_drop", TX_En_Sig, 0);
        repeat (GAP_CYC) step();
        write_byte(8'hAA, 1);
        check("fp_cnt", Fifo_Count, DEPTH);
        check("fp_full_kept", Fifo_Full, 1);
        check("fp_ovf", Overflow_Flag, 0);
        check("fp_en_low", TX_En_Sig, 0);
        step();
        check("fp_en_rise", TX_En_Sig, 1);
        wait_drain("fp", 1000);

        // Asynchronous reset in the middle of a byte with three queued
        reset_dut();
        for (int i = 1; i <= 4; i++)
            write_byte(8'h70 + 8'(i), 1);
        step();
        check("rs_en_before", TX_En_Sig, 1);
        check("rs_cnt_before", Fifo_Count, 3);
        #3;
        RSTn = 1'b0;
        exp_q.delete();
        #1;
        check("rs_en_async", TX_En_Sig, 0);
        check("rs_cnt_async", Fifo_Count, 0);
        check("rs_empty_async", Fifo_Empty, 1);
        repeat (2) step();
        RSTn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (TX_En_Sig)
                check("rs_quiet_en", TX_En_Sig, 0);
        end
        check("rs_quiet_end", TX_En_Sig, 0);

        // Randomised traffic with random responder and stray TX_Done pulses
        reset_dut();
        auto_tx = 1;
        spurious = 1;
        for (int c = 0; c < 600; c++) begin
            step();
            if (Fifo_Count > exp_q.size() || Fifo_Count + 1 < exp_q.size())
                check("rnd_cnt_vs_model", Fifo_Count, exp_q.size());
            if (Fifo_Full !== (Fifo_Count == DEPTH))
                check("rnd_full_consistent", Fifo_Full, Fifo_Count == DEPTH);
            if (Fifo_Empty !== (Fifo_Count == 0))
                check("rnd_empty_consistent", Fifo_Empty, Fifo_Count == 0);
            if (exp_q.size() < DEPTH && $urandom_range(0, 2) == 0) begin
                RX_Data = 8'($urandom);
                RX_Done_Sig = 1'b1;
                exp_q.push_back(RX_Data);
            end
        end
        spurious = 0;
        wait_drain("rnd", 2000);
        check("rnd_ovf", Overflow_Flag, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
- Buffer stage between the UART receiver and transmitter in the echo path.
- Captures each received byte on the receiver's done pulse and queues it in a circular FIFO.
- Presents bytes one at a time to the transmitter with a level enable; releases each on the transmitter's done pulse.
- Removes byte loss when bytes arrive faster than the transmitter drains them.

Parameters:
DATA_W, 8, byte width
ADDR_W, 4, FIFO address bits; depth = 2**ADDR_W (16)
GAP_CYC, 2, cycles TX_En_Sig is held low between consecutive bytes (minimum 1)

Ports:
CLK  in  1  system clock
RSTn  in  1  asynchronous active-low reset
RX_Data  in  DATA_W  received byte, valid in the cycle RX_Done_Sig is high
RX_Done_Sig  in  1  one-cycle pulse, byte received
TX_Done_Sig  in  1  one-cycle pulse, transmitter finished the current byte
TX_En_Sig  out  1  level enable to the transmitter, high while a byte is being sent
TX_Data  out  DATA_W  byte to transmit, stable for the whole time TX_En_Sig is high
Fifo_Count  out  ADDR_W+1  bytes currently stored (0..2**ADDR_W)
Fifo_Full  out  1  Fifo_Count == 2**ADDR_W
Fifo_Empty  out  1  Fifo_Count == 0
Overflow_Flag  out  1  sticky, a byte was dropped

Behaviour:
- Clock and reset: single clock CLK. RSTn is asynchronous active-low.
- Reset values: TX_En_Sig=0, TX_Data=0, Fifo_Count=0, Fifo_Empty=1, Fifo_Full=0, Overflow_Flag=0, wr_ptr=rd_ptr=0, state=IDLE. Storage contents are not reset.
- Write:
  - On RX_Done_Sig=1, RX_Data is stored at wr_ptr and wr_ptr increments (wraps modulo depth).
  - The write is accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped, pointers are unchanged, and Overflow_Flag is set to 1 (cleared only by reset).
- Pop: occurs only on the IDLE->LOAD transition. rd_ptr increments (wraps modulo depth).
- Count:
  - +1 on accepted write without pop.
  - -1 on pop without write.
  - Unchanged when both or neither occur.
  - Full and Empty are registered and consistent with Fifo_Count in the same cycle.
- Read FSM:
  - IDLE: if !Fifo_Empty -> LOAD and pop.
  - LOAD: TX_Data <= mem[popped address]; -> SEND next cycle.
  - SEND: TX_En_Sig=1. TX_Data must not change. On TX_Done_Sig=1 -> GAP and TX_En_Sig=0 from the next cycle.
  - GAP: counter runs GAP_CYC cycles with TX_En_Sig=0, then -> IDLE.
- TX_En_Sig is registered and high exactly in SEND.
- Latency: write into an empty FIFO in IDLE at cycle N gives TX_En_Sig=1 at cycle N+3 (IDLE sees not-empty at N+1, LOAD at N+2, SEND at N+3).
- Back-to-back: the next byte's TX_En_Sig rises GAP_CYC+3 cycles after TX_Done_Sig.
- TX_Done_Sig outside SEND is ignored.
- RX_Done_Sig asserted in any FSM state is handled by the write side independently.
- Asynchronous reset mid-transmission: TX_En_Sig drops immediately, the FIFO is emptied, and the in-flight byte is discarded.
- Memory: a register array or inferred distributed RAM is acceptable. The read is registered in LOAD.

Test Plan:
- Reset then idle 20 cycles -> TX_En_Sig=0, Fifo_Empty=1, Fifo_Count=0, Overflow_Flag=0.
- Single byte: RX_Data=8'h5A with RX_Done_Sig at cycle N -> TX_En_Sig=1 at N+3 with TX_Data=8'h5A. TX_Done_Sig at N+20 -> TX_En_Sig=0 at N+21, Fifo_Count back to 0.
- Burst: write 8'h01..8'h05 on consecutive cycles while SEND is stalled -> Fifo_Count peaks at 4 (one byte popped). TX_Data sequence is 01,02,03,04,05 across five TX_Done_Sig pulses. TX_En_Sig is low for exactly GAP_CYC+2 cycles between bytes.
- Overflow: with TX_Done_Sig never asserted, write 18 bytes -> Fifo_Full=1 after the 17th write (16 stored + 1 in SEND). The 18th is dropped, Overflow_Flag=1. Subsequent TX_Data order matches bytes 1..17.
- Full with simultaneous write and pop: FIFO full in GAP. The cycle the FSM leaves IDLE, also pulse RX_Done_Sig with 8'hAA -> write accepted, Fifo_Count stays 16, Overflow_Flag stays 0, and 8'hAA is transmitted last.
- Reset during SEND: assert RSTn=0 mid-byte with 3 queued -> TX_En_Sig=0 asynchronously, Fifo_Count=0. After release with no input, no TX_En_Sig for 20 cycles.
